// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter/sequencer sharing one AES core between four requesters.
// Latency: grant in cycle 0, core_en from cycle 1, rsp_valid the cycle after core_done (or after abort).
// Backpressure: response held in RESP until rsp_ready; no new grant until that handshake completes.
// Build option: define AES_ARB_TIMEOUT_EN to include the BUSY timeout counter and abort path.
module aes_core_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_valid,
  output logic [3:0]   req_ready,
  input  logic [3:0]   req_decrypt,
  input  logic [511:0] req_key,
  input  logic [511:0] req_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [1:0]   rsp_id,
  output logic [127:0] rsp_data,
  output logic         rsp_error,
  output logic         core_en,
  output logic         core_decrypt,
  output logic [127:0] core_key,
  output logic [127:0] core_state,
  input  logic         core_done,
  input  logic [127:0] core_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Everything captured from the winning requester at grant time.
  typedef struct packed {
    logic [1:0]   id;
    logic         decrypt;
    logic [127:0] key;
    logic [127:0] data;
  } op_t;

  state_t       state;
  state_t       state_nxt;
  op_t          op_q;
  logic [1:0]   ptr;
  logic         gnt_vld;
  logic [1:0]   gnt_id;
  logic [1:0]   scan_id;
  logic         to_hit;
  logic [127:0] rsp_data_q;

  // The timeout counter is 7 bits wide, so the parameter must stay in 2..127.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 127) begin : g_timeout_range
    $error("aes_core_arbiter: TIMEOUT_CYCLES must be in 2..127");
  end

  // Round-robin pick: first valid requester at or above ptr, wrapping modulo 4.
  // Scanning from the far end lets the nearest valid requester overwrite the others.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = ptr;
    scan_id = ptr;
    for (int i = 3; i >= 0; i--) begin
      scan_id = ptr + 2'(i);
      if (req_valid[scan_id]) begin
        gnt_vld = 1'b1;
        gnt_id  = scan_id;
      end
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  logic [6:0] to_cnt;
  logic       rsp_error_q;

  // Cycles spent in BUSY; restarts from 0 for every operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state == BUSY) begin
      to_cnt <= to_cnt + 7'd1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign to_hit = (to_cnt == 7'(TIMEOUT_CYCLES - 1));

  // Error flag: set by an abort, cleared by a real completion (completion wins a tie).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_error_q <= 1'b0;
    end else if (state == BUSY) begin
      if (core_done) begin
        rsp_error_q <= 1'b0;
      end else if (to_hit) begin
        rsp_error_q <= 1'b1;
      end
    end
  end

  assign rsp_error = rsp_error_q;
`else
  // Without the abort path BUSY only ends on core_done.
  assign to_hit    = 1'b0;
  assign rsp_error = 1'b0;
`endif

  // State register; async reset also drops core_en, which decodes from it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: grant from IDLE, finish or abort in BUSY, wait for the consumer in RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = BUSY;
      BUSY:    if (core_done || to_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; req_ready is gated by rst so it is zero while reset is held.
  always_comb begin
    req_ready = 4'b0000;
    core_en   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:    if (gnt_vld && rst) req_ready = 4'b0001 << gnt_id;
      BUSY:    core_en = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture the granted request; it stays put until the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q <= '0;
    end else if (state == IDLE && gnt_vld) begin
      op_q.id      <= gnt_id;
      op_q.decrypt <= req_decrypt[gnt_id];
      op_q.key     <= req_key[gnt_id*128 +: 128];
      op_q.data    <= req_data[gnt_id*128 +: 128];
    end
  end

  // Priority pointer moves past the served requester once its response is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 2'd0;
    end else if (state == RESP && rsp_ready) begin
      ptr <= op_q.id + 2'd1;
    end
  end

  // Response data: core result on completion, zero on abort; core_done elsewhere is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data_q <= '0;
    end else if (state == BUSY) begin
      if (core_done) begin
        rsp_data_q <= core_result;
      end else if (to_hit) begin
        rsp_data_q <= '0;
      end
    end
  end

  assign rsp_data     = rsp_data_q;
  assign rsp_id       = op_q.id;
  assign core_key     = op_q.key;
  assign core_state   = op_q.data;
  assign core_decrypt = op_q.decrypt;

  // At most one requester is granted, and the core is never enabled while a response waits.
  assert property (@(posedge clk) disable iff (!rst) $onehot0(req_ready));
  assert property (@(posedge clk) disable iff (!rst) rsp_valid |-> !core_en);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: transaction-level model plus directed scenarios.
// The core is modelled as a fixed-latency responder counting core_en-high cycles.
// Inputs change just after posedge; all checks sample on negedge.
module tb_aes_core_arbiter;
  localparam int TO = 16;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [3:0]   req_decrypt = '0;
  logic [511:0] req_key = '0;
  logic [511:0] req_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [1:0]   rsp_id;
  logic [127:0] rsp_data;
  logic         rsp_error;
  logic         core_en;
  logic         core_decrypt;
  logic [127:0] core_key;
  logic [127:0] core_state;
  logic         core_done = 1'b0;
  logic [127:0] core_result = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int core_lat = 3;
  int core_cnt = 0;
  bit stray_req = 1'b0;

  aes_core_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_decrypt(req_decrypt),
    .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_error(rsp_error),
    .core_en(core_en), .core_decrypt(core_decrypt), .core_key(core_key),
    .core_state(core_state), .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: expected event not seen within cycle budget (cycle %0d)", name, cyc);
  endtask

  // Stand-in for the AES transform: the FIPS-197 vector, otherwise a reversible mix.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d, input logic dec);
    if (!dec && k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
    return {k[63:0] ^ d[127:64], k[127:64] ^ d[63:0]} ^ {128{dec}};
  endfunction

  function automatic logic [127:0] mk_key(input int n);
    return 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0 ^ {96'd0, 32'(n)};
  endfunction

  function automatic logic [127:0] mk_dat(input int n);
    return 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 ^ {32'(n), 96'd0};
  endfunction

  // Core model: pulse core_done on the core_lat-th enabled cycle (0 = never).
  // A stray pulse carries random data so that capturing it would show up.
  always @(posedge clk) begin
    #1;
    if (core_en) core_cnt = core_cnt + 1;
    else         core_cnt = 0;
    core_done = (core_en && core_lat != 0 && core_cnt == core_lat) || stray_req;
    if (core_done && core_en && !stray_req) core_result = core_fn(core_key, core_state, core_decrypt);
    else core_result = {$urandom, $urandom, $urandom, $urandom};
    stray_req = 1'b0;
  end

  // Transaction model and the single per-cycle compare process.
  bit           m_out = 1'b0;
  bit           m_rsp = 1'b0;
  int           m_ptr = 0;
  int           g_id = 0;
  logic [127:0] g_key = '0;
  logic [127:0] g_data = '0;
  logic         g_dec = 1'b0;
  logic [127:0] e_data = '0;
  logic         e_err = 1'b0;
  int           busy_n = 0;

  always @(negedge clk) begin
    int pick;
    pick = -1;
    if (!rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_error", rsp_error, 0);
      chk("rst_core_en", core_en, 0);
      chk("rst_core_decrypt", core_decrypt, 0);
      chk("rst_core_key", core_key, 0);
      chk("rst_core_state", core_state, 0);
      m_out = 1'b0;
      m_rsp = 1'b0;
      m_ptr = 0;
    end else if (!m_out) begin
      for (int k = 0; k < 4; k++)
        if (pick < 0 && req_valid[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
      chk("idle_req_ready", req_ready, (pick < 0) ? 0 : (1 << pick));
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_core_en", core_en, 0);
      if (pick >= 0) begin
        m_out  = 1'b1;
        m_rsp  = 1'b0;
        g_id   = pick;
        g_key  = req_key[pick*128 +: 128];
        g_data = req_data[pick*128 +: 128];
        g_dec  = req_decrypt[pick];
        busy_n = 0;
      end
    end else if (!m_rsp) begin
      chk("busy_core_en", core_en, 1);
      chk("busy_core_key", core_key, g_key);
      chk("busy_core_state", core_state, g_data);
      chk("busy_core_decrypt", core_decrypt, g_dec);
      chk("busy_req_ready", req_ready, 0);
      chk("busy_rsp_valid", rsp_valid, 0);
      busy_n++;
      if (core_done) begin
        e_data = core_fn(g_key, g_data, g_dec);
        e_err  = 1'b0;
        m_rsp  = 1'b1;
      end
`ifdef AES_ARB_TIMEOUT_EN
      else if (busy_n == TO) begin
        e_data = '0;
        e_err  = 1'b1;
        m_rsp  = 1'b1;
      end
`endif
    end else begin
      chk("resp_rsp_valid", rsp_valid, 1);
      chk("resp_rsp_id", rsp_id, g_id);
      chk("resp_rsp_data", rsp_data, e_data);
      chk("resp_rsp_error", rsp_error, e_err);
      chk("resp_req_ready", req_ready, 0);
      chk("resp_core_en", core_en, 0);
      if (rsp_ready) begin
        m_out = 1'b0;
        m_ptr = (g_id + 1) % 4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [127:0] k, input logic [127:0] d, input logic dec);
    req_key[id*128 +: 128]  = k;
    req_data[id*128 +: 128] = d;
    req_decrypt[id]         = dec;
    req_valid[id]           = 1'b1;
  endtask

  // Returns the granted requester and the grant cycle; ends just after the grant edge.
  task automatic wait_grant(output int id, output int gc);
    id = -1;
    gc = 0;
    for (int i = 0; i < 100 && id < 0; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        if (req_ready[k]) begin
          id = k;
          gc = cyc;
        end
    end
    if (id < 0) bound_fail("wait_grant");
    tick();
  endtask

  task automatic wait_rsp();
    int i;
    i = 0;
    while (!rsp_valid && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (!rsp_valid) bound_fail("wait_rsp");
  endtask

  task automatic wait_hs();
    int i;
    i = 0;
    while (!(rsp_valid && rsp_ready) && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (!(rsp_valid && rsp_ready)) bound_fail("wait_handshake");
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int id;
    int gc;
    int got [8];
    int exp_rr [8];
    exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};

    // Reset with all four requesters already asking: nothing may be granted.
    for (int k = 0; k < 4; k++) set_req(k, mk_key(k), mk_dat(k), k[0]);
    repeat (3) tick();
    chk("reset_req_ready_lit", req_ready, 4'b0000);
    chk("reset_core_en_lit", core_en, 0);
    rst = 1'b1;

    // Round-robin fairness with all requesters held valid.
    core_lat = 3;
    for (int t = 0; t < 8; t++) begin
      wait_grant(id, gc);
      got[t] = id;
      if (t == 7) req_valid = '0;
      wait_rsp();
      chk("rr_latency", cyc - gc, 4);
      wait_hs();
    end
    for (int t = 0; t < 8; t++) chk("rr_order", got[t], exp_rr[t]);

    // Single FIPS-197 encrypt from requester 2.
    core_lat = 10;
    set_req(2, FIPS_KEY, FIPS_PT, 1'b0);
    wait_grant(id, gc);
    req_valid = '0;
    chk("fips_grant", id, 2);
    wait_rsp();
    chk("fips_latency", cyc - gc, 11);
    chk("fips_rsp_id", rsp_id, 2);
    chk("fips_rsp_data", rsp_data, FIPS_CT);
    chk("fips_rsp_error", rsp_error, 0);
    wait_hs();

    // Decrypt on requester 1.
    core_lat = 5;
    set_req(1, mk_key(21), mk_dat(21), 1'b1);
    wait_grant(id, gc);
    req_valid = '0;
    chk("dec_grant", id, 1);
    chk("dec_core_en", core_en, 1);
    chk("dec_core_decrypt", core_decrypt, 1);
    wait_rsp();
    chk("dec_latency", cyc - gc, 6);
    chk("dec_rsp_id", rsp_id, 1);
    wait_hs();

    // Backpressure: response held, a stray core_done arrives, requester 3 waits.
    core_lat = 4;
    rsp_ready = 1'b0;
    set_req(0, mk_key(30), mk_dat(30), 1'b0);
    wait_grant(id, gc);
    req_valid = '0;
    chk("bp_grant", id, 0);
    wait_rsp();
    tick();
    set_req(3, mk_key(31), mk_dat(31), 1'b0);
    for (int t = 0; t < 5; t++) begin
      if (t == 1) stray_req = 1'b1;
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, core_fn(mk_key(30), mk_dat(30), 1'b0));
      chk("bp_req_ready", req_ready, 4'b0000);
    end
    tick();
    rsp_ready = 1'b1;
    wait_hs();
    chk("bp_next_grant", req_ready, 4'b1000);
    wait_grant(id, gc);
    req_valid = '0;
    chk("bp_grant_after", id, 3);
    wait_rsp();
    wait_hs();

`ifdef AES_ARB_TIMEOUT_EN
    // Core never answers: abort after TO busy cycles.
    core_lat = 0;
    set_req(1, mk_key(40), mk_dat(40), 1'b0);
    wait_grant(id, gc);
    req_valid = '0;
    wait_rsp();
    chk("to_latency", cyc - gc, 17);
    chk("to_rsp_error", rsp_error, 1);
    chk("to_rsp_data", rsp_data, 0);
    chk("to_core_en", core_en, 0);
    wait_hs();
    repeat (3) tick();
    chk("to_core_en_after", core_en, 0);
    // Completion on the last busy cycle beats the timeout.
    core_lat = 16;
    set_req(1, mk_key(41), mk_dat(41), 1'b0);
    wait_grant(id, gc);
    req_valid = '0;
    wait_rsp();
    chk("to_tie_latency", cyc - gc, 17);
    chk("to_tie_rsp_error", rsp_error, 0);
    chk("to_tie_rsp_data", rsp_data, core_fn(mk_key(41), mk_dat(41), 1'b0));
    wait_hs();
`else
    // No abort path: a slow core is waited for well past TO cycles.
    core_lat = 60;
    set_req(1, mk_key(40), mk_dat(40), 1'b0);
    wait_grant(id, gc);
    req_valid = '0;
    wait_rsp();
    chk("slow_latency", cyc - gc, 61);
    chk("slow_rsp_error", rsp_error, 0);
    chk("slow_rsp_data", rsp_data, core_fn(mk_key(40), mk_dat(40), 1'b0));
    wait_hs();
`endif

    // Reset during the third busy cycle, then ptr must be back at 0.
    core_lat = 10;
    set_req(2, mk_key(50), mk_dat(50), 1'b1);
    set_req(3, mk_key(51), mk_dat(51), 1'b0);
    wait_grant(id, gc);
    req_valid[2] = 1'b0;
    chk("mid_rst_grant", id, 2);
    tick();
    tick();
    #1;
    chk("pre_rst_core_en", core_en, 1);
    rst = 1'b0;
    #1;
    chk("rst_async_core_en", core_en, 0);
    chk("rst_async_rsp_valid", rsp_valid, 0);
    chk("rst_async_req_ready", req_ready, 4'b0000);
    chk("rst_async_core_key", core_key, 0);
    tick();
    tick();
    set_req(1, mk_key(52), mk_dat(52), 1'b0);
    rst = 1'b1;
    wait_grant(id, gc);
    req_valid = '0;
    chk("post_rst_grant", id, 1);
    wait_rsp();
    wait_hs();
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
